// File: rtl/gsu_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module : gsu_rom_pkg
// Brief  : Shared constants for the GSU ROM port sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package gsu_rom_pkg;

    localparam int ROM_ADDR_W = 24;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_BUF   = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rom_wait_counter.sv
`default_nettype none
// ============================================================================
// Module : rom_wait_counter
// Brief  : 4-bit loadable down-counter with zero flag and synchronous abort.
// Rev    : 1.0  initial release
// ============================================================================
module rom_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       abort,
    output logic       zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (abort) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/rom_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module : rom_fetch_scheduler
// Brief  : Arbitrates cache fills and ROM-buffer reads onto the 8-bit ROM port.
// Rev    : 1.0  initial release
// ============================================================================
module rom_fetch_scheduler
    import gsu_rom_pkg::*;
#(
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ROM_ADDR_W-1:0] fetch_addr,
    output logic                  romrdy,
    output logic [7:0]            instr_data,
    input  logic                  buf_req,
    input  logic [ROM_ADDR_W-1:0] buf_addr,
    output logic                  buf_valid,
    output logic [7:0]            buf_data,
    output logic                  buf_busy,
    input  logic                  rom_owner,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_oe,
    input  logic [7:0]            rom_rd_data
);

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    logic                  r_granted;
    logic                  r_last_grant;
    logic                  r_buf_pending;
    logic [ROM_ADDR_W-1:0] r_buf_addr;

    logic   w_grant;
    logic   w_grant_buf;
    logic   w_abort;
    logic   w_finish;
    logic   w_cnt_zero;
    state_t w_state_n;
    logic   w_granted_n;
    logic   w_pending_n;

    // Ties go to whoever was not served last; a lone requester always wins.
    assign w_grant     = (r_state == ST_IDLE) && rom_owner && (fetch_req || r_buf_pending);
    assign w_grant_buf = r_buf_pending && (!fetch_req || (r_last_grant == REQ_FETCH));
    assign w_abort     = (r_state == ST_ACCESS) && !rom_owner;
    assign w_finish    = (r_state == ST_ACCESS) && rom_owner && w_cnt_zero;

    always_comb begin
        w_state_n   = r_state;
        w_granted_n = r_granted;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_n   = ST_ACCESS;
                    w_granted_n = w_grant_buf ? REQ_BUF : REQ_FETCH;
                end
            end
            ST_ACCESS: begin
                if (w_abort) begin
                    w_state_n = ST_IDLE;
                end else if (w_finish) begin
                    w_state_n = ST_DONE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Pending is consumed at grant; an abort re-arms it, a fresh buf_req always sets it.
    assign w_pending_n = buf_req
                       | (r_buf_pending & ~(w_grant & w_grant_buf))
                       | (w_abort & (r_granted == REQ_BUF));

    rom_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_grant),
        .load_val (C_WAIT_LOAD),
        .dec      ((r_state == ST_ACCESS) && rom_owner),
        .abort    (w_abort),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_granted     <= REQ_FETCH;
            r_last_grant  <= REQ_BUF;
            r_buf_pending <= 1'b0;
            r_buf_addr    <= '0;
            rom_addr      <= '0;
            rom_oe        <= 1'b0;
            romrdy        <= 1'b0;
            buf_valid     <= 1'b0;
            instr_data    <= 8'd0;
            buf_data      <= 8'd0;
            buf_busy      <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_granted     <= w_granted_n;
            r_buf_pending <= w_pending_n;
            buf_busy      <= w_pending_n | ((w_granted_n == REQ_BUF) && (w_state_n != ST_IDLE));
            romrdy        <= w_finish && (r_granted == REQ_FETCH);
            buf_valid     <= w_finish && (r_granted == REQ_BUF);
            if (buf_req) begin
                r_buf_addr <= buf_addr;
            end
            if (w_grant) begin
                rom_addr <= w_grant_buf ? r_buf_addr : fetch_addr;
                rom_oe   <= 1'b1;
            end else if (w_abort || w_finish) begin
                rom_oe   <= 1'b0;
            end
            if (w_finish) begin
                if (r_granted == REQ_BUF) begin
                    buf_data <= rom_rd_data;
                end else begin
                    instr_data <= rom_rd_data;
                end
            end
            if (r_state == ST_DONE) begin
                r_last_grant <= r_granted;
            end
        end
    end

endmodule
`default_nettype wire
